// File: rtl/nfu_pkg.sv
// Shared constants and state type for the nonlinear function unit sequencer.
package nfu_pkg;

    localparam logic [1:0] MODE_SOFTMAX = 2'd0;
    localparam logic [1:0] MODE_GELU    = 2'd1;
    localparam logic [1:0] MODE_SILU    = 2'd2;
    localparam logic [1:0] MODE_ROOT    = 2'd3;

    localparam logic [2:0] S_SM1  = 3'd0;
    localparam logic [2:0] S_SM2  = 3'd1;
    localparam logic [2:0] S_ACT1 = 3'd2;
    localparam logic [2:0] S_ACT2 = 3'd3;
    localparam logic [2:0] S_PASS = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StIssue1,
        StWait1,
        StIssue2,
        StWait2,
        StDone
    } nfu_state_e;

endpackage

// File: rtl/nfu_round_plan.sv
// Maps a function mode and round index to the selector stage code and a last-round flag.
module nfu_round_plan
    import nfu_pkg::*;
(
    input  logic [1:0] i_mode,
    input  logic       i_round,
    output logic [2:0] o_stage,
    output logic       o_last
);

    always_comb begin
        o_stage = S_PASS;
        o_last  = 1'b1;
        case (i_mode)
            MODE_SOFTMAX: begin
                o_stage = i_round ? S_SM2 : S_SM1;
                o_last  = i_round;
            end
            MODE_GELU, MODE_SILU: begin
                o_stage = i_round ? S_ACT2 : S_ACT1;
                o_last  = i_round;
            end
            MODE_ROOT: begin
                // Single pass-through round; a second round index never occurs.
                o_stage = S_PASS;
                o_last  = 1'b1;
            end
            default: begin
                o_stage = S_PASS;
                o_last  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/nfu_round_sequencer.sv
// Steps the operand selector and shared multiply-add unit through one or two evaluation
// rounds per job, returning the final-round result on an output handshake.
module nfu_round_sequencer
    import nfu_pkg::*;
#(
    parameter int unsigned FIX_POINT_WIDTH = 16,
    parameter int unsigned MAX_WAIT        = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [1:0]                 job_mode,
    input  logic [FIX_POINT_WIDTH-1:0] job_x,
    input  logic [FIX_POINT_WIDTH-1:0] job_max,
    input  logic [FIX_POINT_WIDTH-1:0] job_sum,
    input  logic [FIX_POINT_WIDTH-1:0] job_u,
    output logic [1:0]                 sel_mode,
    output logic [2:0]                 sel_s,
    output logic [FIX_POINT_WIDTH-1:0] sel_x,
    output logic [FIX_POINT_WIDTH-1:0] sel_max,
    output logic [FIX_POINT_WIDTH-1:0] sel_mid,
    output logic [FIX_POINT_WIDTH-1:0] sel_sum,
    output logic [FIX_POINT_WIDTH-1:0] sel_u,
    output logic                       issue,
    input  logic                       res_valid,
    input  logic [FIX_POINT_WIDTH-1:0] res_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FIX_POINT_WIDTH-1:0] out_data,
    output logic                       err
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 2);

    nfu_state_e                 r_state;
    logic [CntW-1:0]            r_wait_cnt;
    logic                       r_single;
    logic                       r_job_ready;
    logic [1:0]                 r_mode;
    logic [2:0]                 r_sel_s;
    logic [FIX_POINT_WIDTH-1:0] r_x;
    logic [FIX_POINT_WIDTH-1:0] r_max;
    logic [FIX_POINT_WIDTH-1:0] r_mid;
    logic [FIX_POINT_WIDTH-1:0] r_sum;
    logic [FIX_POINT_WIDTH-1:0] r_u;
    logic                       r_issue;
    logic                       r_out_valid;
    logic [FIX_POINT_WIDTH-1:0] r_out_data;
    logic                       r_err;

    logic [1:0]                 w_plan_mode;
    logic                       w_plan_round;
    logic [2:0]                 w_plan_stage;
    logic                       w_plan_last;
    logic                       w_timeout;
    logic                       w_in_wait;

    // In IDLE the plan looks at the incoming job's first round; elsewhere it supplies the
    // latched job's second round, which is only consumed on the WAIT1 -> ISSUE2 step.
    assign w_plan_mode  = (r_state == StIdle) ? job_mode : r_mode;
    assign w_plan_round = (r_state != StIdle);

    nfu_round_plan u_plan (
        .i_mode  (w_plan_mode),
        .i_round (w_plan_round),
        .o_stage (w_plan_stage),
        .o_last  (w_plan_last)
    );

    assign w_timeout = (r_wait_cnt == CntW'(MAX_WAIT));
    assign w_in_wait = (r_state == StWait1) || (r_state == StWait2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_wait_cnt  <= '0;
            r_single    <= 1'b0;
            r_job_ready <= 1'b1;
            r_mode      <= 2'd0;
            r_sel_s     <= 3'd0;
            r_x         <= '0;
            r_max       <= '0;
            r_mid       <= '0;
            r_sum       <= '0;
            r_u         <= '0;
            r_issue     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_issue <= 1'b0;
            if (res_valid && !w_in_wait) begin
                r_err <= 1'b1;
            end

            case (r_state)
                StIdle: begin
                    if (job_valid) begin
                        r_mode      <= job_mode;
                        r_x         <= job_x;
                        r_max       <= job_max;
                        r_sum       <= job_sum;
                        r_u         <= job_u;
                        r_mid       <= '0;
                        r_single    <= w_plan_last;
                        r_sel_s     <= w_plan_stage;
                        r_issue     <= 1'b1;
                        r_job_ready <= 1'b0;
                        r_state     <= StIssue1;
                    end
                end

                StIssue1: begin
                    r_wait_cnt <= '0;
                    r_state    <= StWait1;
                end

                StWait1: begin
                    if (res_valid) begin
                        if (r_single) begin
                            r_out_data  <= res_data;
                            r_out_valid <= 1'b1;
                            r_state     <= StDone;
                        end else begin
                            r_mid   <= res_data;
                            r_sel_s <= w_plan_stage;
                            r_issue <= 1'b1;
                            r_state <= StIssue2;
                        end
                    end else if (w_timeout) begin
                        r_err       <= 1'b1;
                        r_out_data  <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CntW'(1);
                    end
                end

                StIssue2: begin
                    r_wait_cnt <= '0;
                    r_state    <= StWait2;
                end

                StWait2: begin
                    if (res_valid) begin
                        r_out_data  <= res_data;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end else if (w_timeout) begin
                        r_err       <= 1'b1;
                        r_out_data  <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CntW'(1);
                    end
                end

                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_job_ready <= 1'b1;
                        r_sel_s     <= 3'd0;
                        r_state     <= StIdle;
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign job_ready = r_job_ready;
    assign sel_mode  = r_mode;
    assign sel_s     = r_sel_s;
    assign sel_x     = r_x;
    assign sel_max   = r_max;
    assign sel_mid   = r_mid;
    assign sel_sum   = r_sum;
    assign sel_u     = r_u;
    assign issue     = r_issue;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign err       = r_err;

endmodule
